// File: rtl/alarm_scheduler.sv
// Multi-channel alarm engine: per-channel compare FSM in the clk_i domain, with each
// fire event carried into the clk_alarm_i domain as a toggle and re-emitted as one pulse.
module alarm_scheduler #(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_CHANNELS    = 10,
  parameter int SYNC_STAGES    = 2,
  parameter int MIN_GAP        = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_an_i,
  input  logic                                  rst_i,
  input  logic [NB_CHANNELS-1:0]                arm_i,
  input  logic [NB_CHANNELS-1:0]                periodic_i,
  input  logic [NB_CHANNELS-1:0]                cmp_ge_i,
  input  logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] alarm_i,
  input  logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] period_i,
  input  logic [TIMER_BITWIDTH*NB_CHANNELS-1:0] counter_i,
  input  logic [NB_CHANNELS-1:0]                clear_i,
  input  logic                                  clk_alarm_i,
  output logic [NB_CHANNELS-1:0]                armed_o,
  output logic [NB_CHANNELS-1:0]                pending_o,
  output logic [NB_CHANNELS-1:0]                overrun_o,
  output logic [NB_CHANNELS-1:0]                alarm_o
);

  localparam int GAP_W = $clog2(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 1);
  localparam logic [TIMER_BITWIDTH-1:0] HALF_RANGE = {1'b1, {(TIMER_BITWIDTH-1){1'b0}}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_FIRING = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  for (genvar ch = 0; ch < NB_CHANNELS; ch++) begin : g_ch
    logic [1:0]                state_q;
    logic [TIMER_BITWIDTH-1:0] target_q;
    logic [GAP_W-1:0]          gap_q;
    logic                      arm_q;
    logic                      pending_q;
    logic                      overrun_q;
    logic                      toggle_q;
    logic [SYNC_STAGES-1:0]    sync_q;
    logic                      edge_q;
    logic                      alarm_q;

    logic [TIMER_BITWIDTH-1:0] alarm_val;
    logic [TIMER_BITWIDTH-1:0] period_val;
    logic [TIMER_BITWIDTH-1:0] counter_val;
    logic [TIMER_BITWIDTH-1:0] diff;
    logic                      match;
    logic                      fire;
    logic                      ovr_set;

    assign alarm_val   = alarm_i[ch*TIMER_BITWIDTH +: TIMER_BITWIDTH];
    assign period_val  = period_i[ch*TIMER_BITWIDTH +: TIMER_BITWIDTH];
    assign counter_val = counter_i[ch*TIMER_BITWIDTH +: TIMER_BITWIDTH];

    // Reached compare: counter lies in the half range at or after the target.
    assign diff    = counter_val - target_q;
    assign match   = cmp_ge_i[ch] ? (diff < HALF_RANGE) : (counter_val == target_q);
    assign fire    = !rst_i && arm_i[ch] && match && (state_q == ST_ARMED);
    assign ovr_set = match && (state_q == ST_FIRING);

    assign armed_o[ch]   = (state_q == ST_ARMED) || (state_q == ST_FIRING);
    assign pending_o[ch] = pending_q;
    assign overrun_o[ch] = overrun_q;
    assign alarm_o[ch]   = alarm_q;

    always_ff @(posedge clk_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
        state_q   <= ST_IDLE;
        target_q  <= '0;
        gap_q     <= '0;
        arm_q     <= 1'b0;
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        arm_q <= arm_i[ch];
        // The toggle is left alone by the soft reset so it can never emit a phantom pulse.
        if (fire) begin
          toggle_q <= ~toggle_q;
        end
        if (rst_i) begin
          state_q   <= ST_IDLE;
          target_q  <= '0;
          pending_q <= 1'b0;
          overrun_q <= 1'b0;
        end else begin
          pending_q <= fire || (pending_q && !clear_i[ch]);
          overrun_q <= ovr_set || (overrun_q && !clear_i[ch]);
          case (state_q)
            ST_IDLE: begin
              if (arm_i[ch] && !arm_q) begin
                state_q  <= ST_ARMED;
                target_q <= alarm_val;
              end
            end
            ST_ARMED: begin
              if (!arm_i[ch]) begin
                state_q <= ST_IDLE;
              end else if (match) begin
                state_q <= ST_FIRING;
                gap_q   <= GAP_LOAD;
              end
            end
            ST_FIRING: begin
              if (!arm_i[ch]) begin
                state_q <= ST_IDLE;
              end else if (gap_q == '0) begin
                if (periodic_i[ch] && (period_val != '0)) begin
                  target_q <= target_q + period_val;
                  state_q  <= ST_ARMED;
                end else begin
                  state_q <= ST_DONE;
                end
              end else begin
                gap_q <= gap_q - 1'b1;
              end
            end
            ST_DONE: begin
              if (!arm_i[ch]) begin
                state_q <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end

    // Destination side: synchronise the toggle, then turn each change into one pulse.
    always_ff @(posedge clk_alarm_i or negedge rst_an_i) begin
      if (!rst_an_i) begin
        sync_q  <= '0;
        edge_q  <= 1'b0;
        alarm_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], toggle_q};
        edge_q  <= sync_q[SYNC_STAGES-1];
        alarm_q <= sync_q[SYNC_STAGES-1] ^ edge_q;
      end
    end
  end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: a cycle-level behavioural model is compared against
// the DUT every clk_i cycle, alarm_o pulses are counted per channel, and key results are pinned.
module tb_alarm_scheduler;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;
  localparam int G = 4;

  logic clk_i = 1'b0;
  logic clk_alarm_i = 1'b0;
  logic rst_an_i = 1'b0;
  logic rst_i = 1'b0;
  logic [N-1:0] arm = '0;
  logic [N-1:0] periodic = '0;
  logic [N-1:0] cmp_ge = '0;
  logic [N-1:0] clear = '0;
  logic [W-1:0] alarm_v [N];
  logic [W-1:0] period_v [N];
  logic [W-1:0] counter_v [N];
  logic [W*N-1:0] alarm_bus;
  logic [W*N-1:0] period_bus;
  logic [W*N-1:0] counter_bus;
  logic [N-1:0] armed_o;
  logic [N-1:0] pending_o;
  logic [N-1:0] overrun_o;
  logic [N-1:0] alarm_o;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  int cyc = 0;
  int m_target [N];
  bit m_engaged [N];
  bit m_waiting [N];
  bit m_done [N];
  bit m_pending [N];
  bit m_overrun [N];
  bit m_prev_arm [N];
  int m_fire_cyc [N];
  int m_fires [N];
  int fire_log [N][16];
  int pulse_cnt [N];

  always_comb begin
    alarm_bus = '0;
    period_bus = '0;
    counter_bus = '0;
    for (int c = 0; c < N; c++) begin
      alarm_bus[c*W +: W] = alarm_v[c];
      period_bus[c*W +: W] = period_v[c];
      counter_bus[c*W +: W] = counter_v[c];
    end
  end

  alarm_scheduler #(
    .TIMER_BITWIDTH(W),
    .NB_CHANNELS(N),
    .SYNC_STAGES(S),
    .MIN_GAP(G)
  ) dut (
    .clk_i(clk_i),
    .rst_an_i(rst_an_i),
    .rst_i(rst_i),
    .arm_i(arm),
    .periodic_i(periodic),
    .cmp_ge_i(cmp_ge),
    .alarm_i(alarm_bus),
    .period_i(period_bus),
    .counter_i(counter_bus),
    .clear_i(clear),
    .clk_alarm_i(clk_alarm_i),
    .armed_o(armed_o),
    .pending_o(pending_o),
    .overrun_o(overrun_o),
    .alarm_o(alarm_o)
  );

  // clk_i period 10; clk_alarm_i period 30, offset so the two never share an edge.
  always #5 clk_i = ~clk_i;
  initial begin
    #2;
    forever #15 clk_alarm_i = ~clk_alarm_i;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  // Behavioural model: a channel is engaged from arming until it finishes or is dropped;
  // it waits for the target, then stays busy for G cycles counted from the fire edge.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    for (int c = 0; c < N; c++) begin
      bit rise;
      bit reached;
      bit fired;
      bit ovr;
      int diff;
      rise = arm[c] && !m_prev_arm[c];
      diff = (int'(counter_v[c]) - m_target[c]) & 255;
      reached = cmp_ge[c] ? (diff < 128) : (diff == 0);
      fired = 0;
      ovr = 0;
      if (!rst_an_i) begin
        m_engaged[c] = 0; m_waiting[c] = 0; m_done[c] = 0; m_target[c] = 0;
        m_pending[c] = 0; m_overrun[c] = 0;
      end else if (rst_i) begin
        m_engaged[c] = 0; m_waiting[c] = 0; m_done[c] = 0; m_target[c] = 0;
        m_pending[c] = 0; m_overrun[c] = 0;
      end else begin
        if (m_done[c]) begin
          if (!arm[c]) m_done[c] = 0;
        end else if (!m_engaged[c]) begin
          if (rise) begin
            m_engaged[c] = 1;
            m_waiting[c] = 1;
            m_target[c] = int'(alarm_v[c]);
          end
        end else if (m_waiting[c]) begin
          if (!arm[c]) begin
            m_engaged[c] = 0;
          end else if (reached) begin
            fired = 1;
            m_waiting[c] = 0;
            m_fire_cyc[c] = cyc;
            if (m_fires[c] < 16) fire_log[c][m_fires[c]] = int'(counter_v[c]);
            m_fires[c]++;
          end
        end else begin
          ovr = reached;
          if (!arm[c]) begin
            m_engaged[c] = 0;
          end else if (cyc - m_fire_cyc[c] == G) begin
            if (periodic[c] && period_v[c] != 0) begin
              m_target[c] = (m_target[c] + int'(period_v[c])) & 255;
              m_waiting[c] = 1;
            end else begin
              m_engaged[c] = 0;
              m_done[c] = 1;
            end
          end
        end
        m_pending[c] = fired || (m_pending[c] && !clear[c]);
        m_overrun[c] = ovr || (m_overrun[c] && !clear[c]);
      end
      m_prev_arm[c] = rst_an_i ? arm[c] : 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      for (int c = 0; c < N; c++) begin
        checkOutput($sformatf("armed_o[%0d]", c), int'(armed_o[c]), int'(m_engaged[c]));
        checkOutput($sformatf("pending_o[%0d]", c), int'(pending_o[c]), int'(m_pending[c]));
        checkOutput($sformatf("overrun_o[%0d]", c), int'(overrun_o[c]), int'(m_overrun[c]));
      end
    end
  end

  always @(posedge clk_alarm_i) begin
    #1;
    for (int c = 0; c < N; c++) begin
      if (alarm_o[c]) pulse_cnt[c]++;
    end
  end

  initial begin
    for (int c = 0; c < N; c++) begin
      alarm_v[c] = '0;
      period_v[c] = '0;
      counter_v[c] = '0;
      pulse_cnt[c] = 0;
      m_fires[c] = 0;
      m_fire_cyc[c] = 0;
    end
    applyStimulus(3);
    rst_an_i = 1'b1;
    applyStimulus(1);
    chk_en = 1;
    checkOutput("reset armed_o", int'(armed_o), 0);
    checkOutput("reset pending_o", int'(pending_o), 0);
    checkOutput("reset overrun_o", int'(overrun_o), 0);
    checkOutput("reset alarm_o", int'(alarm_o), 0);

    // One-shot exact compare on channel 0.
    alarm_v[0] = 8'd100; counter_v[0] = 8'd98; arm[0] = 1'b1;
    applyStimulus(1);
    for (int v = 98; v <= 103; v++) begin
      counter_v[0] = W'(v);
      applyStimulus(1);
    end
    applyStimulus(3);
    checkOutput("t1 fires", m_fires[0], 1);
    checkOutput("t1 fire value", fire_log[0][0], 100);
    checkOutput("t1 pending_o", int'(pending_o[0]), 1);
    checkOutput("t1 armed_o in DONE", int'(armed_o[0]), 0);
    arm[0] = 1'b0;
    applyStimulus(15);
    checkOutput("t1 pulses", pulse_cnt[0], 1);

    // Periodic exact compare with target wrap on channel 1.
    alarm_v[1] = 8'd250; period_v[1] = 8'd10; periodic[1] = 1'b1; counter_v[1] = 8'd248;
    arm[1] = 1'b1;
    applyStimulus(1);
    for (int k = 0; k < 26; k++) begin
      counter_v[1] = counter_v[1] + 8'd1;
      applyStimulus(1);
    end
    checkOutput("t2 fires", m_fires[1], 3);
    checkOutput("t2 fire0", fire_log[1][0], 250);
    checkOutput("t2 fire1", fire_log[1][1], 4);
    checkOutput("t2 fire2", fire_log[1][2], 14);
    arm[1] = 1'b0;
    applyStimulus(15);
    checkOutput("t2 pulses", pulse_cnt[1], 3);

    // Reached vs exact compare when the counter skips over the target.
    alarm_v[2] = 8'd50; alarm_v[3] = 8'd50; cmp_ge[2] = 1'b1; cmp_ge[3] = 1'b0;
    counter_v[2] = 8'd47; counter_v[3] = 8'd47; arm[2] = 1'b1; arm[3] = 1'b1;
    applyStimulus(1);
    counter_v[2] = 8'd48; counter_v[3] = 8'd48;
    applyStimulus(1);
    for (int v = 53; v <= 58; v++) begin
      counter_v[2] = W'(v); counter_v[3] = W'(v);
      applyStimulus(1);
    end
    checkOutput("t3 ge fires", m_fires[2], 1);
    checkOutput("t3 ge fire value", fire_log[2][0], 53);
    checkOutput("t3 eq fires", m_fires[3], 0);
    checkOutput("t3 eq still armed", int'(armed_o[3]), 1);
    checkOutput("t3 eq pending_o", int'(pending_o[3]), 0);
    arm[2] = 1'b0; arm[3] = 1'b0;
    applyStimulus(15);
    checkOutput("t3 ge pulses", pulse_cnt[2], 1);
    checkOutput("t3 eq pulses", pulse_cnt[3], 0);

    // Overrun, clear, and clear coincident with a fire on channel 0.
    alarm_v[0] = 8'd20; period_v[0] = 8'd1; periodic[0] = 1'b1; cmp_ge[0] = 1'b1;
    counter_v[0] = 8'd18; arm[0] = 1'b1;
    applyStimulus(1);
    counter_v[0] = 8'd19;
    applyStimulus(1);
    counter_v[0] = 8'd20;
    applyStimulus(1);
    checkOutput("t4 overrun on fire edge", int'(overrun_o[0]), 0);
    counter_v[0] = 8'd21;
    applyStimulus(1);
    checkOutput("t4 overrun after fire", int'(overrun_o[0]), 1);
    arm[0] = 1'b0;
    applyStimulus(1);
    clear[0] = 1'b1;
    applyStimulus(1);
    clear[0] = 1'b0;
    checkOutput("t4 overrun cleared", int'(overrun_o[0]), 0);
    checkOutput("t4 pending cleared", int'(pending_o[0]), 0);
    alarm_v[0] = 8'd30; periodic[0] = 1'b0; cmp_ge[0] = 1'b0; counter_v[0] = 8'd28;
    arm[0] = 1'b1;
    applyStimulus(1);
    counter_v[0] = 8'd29;
    applyStimulus(1);
    counter_v[0] = 8'd30; clear[0] = 1'b1;
    applyStimulus(1);
    clear[0] = 1'b0;
    checkOutput("t4 set wins over clear", int'(pending_o[0]), 1);
    arm[0] = 1'b0;
    applyStimulus(15);
    checkOutput("t4 pulses", pulse_cnt[0], 3);

    // Soft reset while FIRING on channel 1.
    alarm_v[1] = 8'd40; periodic[1] = 1'b0; counter_v[1] = 8'd38; arm[1] = 1'b1;
    applyStimulus(1);
    counter_v[1] = 8'd39;
    applyStimulus(1);
    counter_v[1] = 8'd40;
    applyStimulus(1);
    rst_i = 1'b1;
    applyStimulus(1);
    rst_i = 1'b0;
    checkOutput("t5 armed_o after rst_i", int'(armed_o[1]), 0);
    checkOutput("t5 pending_o after rst_i", int'(pending_o[1]), 0);
    checkOutput("t5 other pending after rst_i", int'(pending_o[0]), 0);
    counter_v[1] = 8'd41;
    applyStimulus(15);
    checkOutput("t5 pulses", pulse_cnt[1], 4);
    arm[1] = 1'b0;
    applyStimulus(2);

    // All channels fire on one edge; each pulse lands S+1 clk_alarm_i edges later.
    for (int c = 0; c < N; c++) begin
      alarm_v[c] = 8'd60; periodic[c] = 1'b0; cmp_ge[c] = 1'b0; counter_v[c] = 8'd58;
    end
    arm = '1;
    applyStimulus(1);
    for (int c = 0; c < N; c++) counter_v[c] = 8'd59;
    applyStimulus(1);
    for (int c = 0; c < N; c++) counter_v[c] = 8'd60;
    @(posedge clk_i);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_alarm_i);
      #1;
      checkOutput($sformatf("t6 alarm_o edge %0d", k), int'(alarm_o), (k == S + 1) ? ((1 << N) - 1) : 0);
    end
    #2;
    arm = '0;
    applyStimulus(15);
    checkOutput("t6 pulses ch0", pulse_cnt[0], 4);
    checkOutput("t6 pulses ch1", pulse_cnt[1], 5);
    checkOutput("t6 pulses ch2", pulse_cnt[2], 2);
    checkOutput("t6 pulses ch3", pulse_cnt[3], 1);
    for (int c = 0; c < N; c++) begin
      checkOutput($sformatf("pulses vs model fires ch%0d", c), pulse_cnt[c], m_fires[c]);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
